// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART_TX-side handshake bundle.
// master = arbiter view, slave = producers + UART_TX view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   req_done;
  logic               tx_en;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic               tx_done;

  modport master (
    input  req_valid, req_data, tx_busy, tx_done,
    output req_ready, req_done, tx_en, tx_data
  );

  modport slave (
    output req_valid, req_data, tx_busy, tx_done,
    input  req_ready, req_done, tx_en, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_TX among N_REQ producers.
// Optional launch-to-done watchdog: `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int GAP_CYC     = 0,
  parameter  int TIMEOUT_CYC = 120000,
  localparam int OW          = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus,
  output logic [OW-1:0]     owner,
  output logic              active,
  output logic              err_timeout
);

  localparam int GW = $clog2(GAP_CYC + 2);
  localparam logic [N_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] win;
  logic          hit;
  logic [GW-1:0] gap_cnt;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // First requester above the rr pointer, wrapping modulo N_REQ.
  always_comb begin
    logic [OW-1:0] idx;
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = OW'((int'(ptr) + k) % N_REQ);
      if (!hit && bus.req_valid[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  // Frame sequencer: grant, launch, wait for done, optional gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= OW'(N_REQ - 1);
      owner         <= '0;
      active        <= 1'b0;
      bus.tx_en     <= 1'b0;
      bus.tx_data   <= '0;
      bus.req_ready <= '0;
      bus.req_done  <= '0;
      gap_cnt       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_timeout   <= 1'b0;
      tmo_cnt       <= '0;
`endif
    end else begin
      bus.req_ready <= '0;
      bus.req_done  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_timeout   <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (hit && !bus.tx_busy) begin
            owner         <= win;
            bus.tx_data   <= bus.req_data[{win, 3'b000} +: 8];
            bus.req_ready <= ONE << win;
            bus.tx_en     <= 1'b1;
            active        <= 1'b1;
            state         <= S_LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        S_LAUNCH, S_WAIT: begin
          if (bus.tx_done) begin
            bus.req_done <= ONE << owner;
            ptr          <= owner;
            active       <= 1'b0;
            bus.tx_en    <= 1'b0;
            gap_cnt      <= GW'(GAP_CYC);
            state        <= (GAP_CYC > 0) ? S_GAP : S_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            err_timeout  <= 1'b1;
            ptr          <= owner;
            active       <= 1'b0;
            bus.tx_en    <= 1'b0;
            state        <= S_IDLE;
`endif
          end else begin
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
            if (state == S_LAUNCH && bus.tx_busy) begin
              bus.tx_en <= 1'b0;
              state     <= S_WAIT;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= GW'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized frames against a transaction-level model.
// Covers timeout build too when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 3;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] owner;
  logic       active;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N),
    .GAP_CYC(GAP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .owner(owner),
    .active(active),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // UART_TX stand-in: busy one edge after tx_en, done after uart_div cycles
  logic u_busy = 1'b0;
  logic u_done = 1'b0;
  int   u_cnt  = 0;
  int   uart_div = 4;
  bit   force_busy = 1'b0;
  bit   stuck = 1'b0;

  always @(posedge clk) begin
    u_done <= 1'b0;
    if (rst) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
    end else if (!u_busy) begin
      if (bus.tx_en && !stuck) begin
        u_busy <= 1'b1;
        u_cnt  <= uart_div;
      end
    end else if (u_cnt <= 1) begin
      u_busy <= 1'b0;
      u_done <= 1'b1;
    end else begin
      u_cnt <= u_cnt - 1;
    end
  end

  assign bus.tx_busy = u_busy | force_busy;
  assign bus.tx_done = u_done;

  // Reference model state
  logic [N-1:0] pend;
  logic [7:0]   dat [N];
  logic [7:0]   g_data;
  int           mptr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    bus.req_valid = pend;
    for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = dat[i];
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic grant_chk(input int w, input int lat);
    int n = 0;
    while (bus.req_ready == '0 && n < 300) begin
      step();
      n++;
    end
    chk("ready_seen", {31'd0, |bus.req_ready}, 1);
    chk("latency", n, lat);
    chk("ready_vec", {28'd0, bus.req_ready}, 32'(1) << w);
    chk("owner", {30'd0, owner}, w);
    chk("tx_data", {24'd0, bus.tx_data}, {24'd0, dat[w]});
    chk("active", {31'd0, active}, 1);
    chk("tx_en_on", {31'd0, bus.tx_en}, 1);
    g_data  = dat[w];
    pend[w] = 1'b0;
    apply();
  endtask

  task automatic finish_chk(input int w);
    int n = 0;
    while (!bus.tx_done && n < 300) begin
      chk("quiet", {23'd0, bus.req_ready, bus.req_done, err_timeout}, 0);
      step();
      n++;
    end
    chk("done_seen", {31'd0, bus.tx_done}, 1);
    chk("data_hold", {24'd0, bus.tx_data}, {24'd0, g_data});
    chk("active_hold", {31'd0, active}, 1);
    step();
    chk("req_done", {28'd0, bus.req_done}, 32'(1) << w);
    chk("active_clr", {31'd0, active}, 0);
    chk("owner_keep", {30'd0, owner}, w);
    mptr = w;
  endtask

  task automatic serve_one(input int lat, input bit disturb);
    int w, n, j;
    w = pick();
    uart_div = $urandom_range(2, 12);
    grant_chk(w, lat);
    n = 0;
    while (bus.tx_en && n < 10) begin
      step();
      n++;
      if (n == 1) chk("ready_pulse", {28'd0, bus.req_ready}, 0);
    end
    chk("tx_en_len", n, 2);
    if (disturb && $urandom_range(0, 2) == 0) begin
      dat[w]  = 8'($urandom);
      pend[w] = 1'b1;
      apply();
    end
    if (disturb && $urandom_range(0, 3) == 0) begin
      j = $urandom_range(0, N - 1);
      if (j != w && pend[j]) begin
        pend[j] = 1'b0;
        apply();
      end
    end
    finish_chk(w);
  endtask

  task automatic run_round(input bit disturb);
    int frames = 0;
    serve_one(1, disturb);
    while (pend != '0 && frames < 20) begin
      serve_one(GAP + 1, disturb);
      frames++;
    end
    pend = '0;
    apply();
    for (int i = 0; i < GAP + 2; i++) begin
      step();
      chk("idle_quiet", {28'd0, bus.req_ready}, 0);
    end
  endtask

  initial begin
    int w, n;
    rst  = 1'b1;
    pend = '1;
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    apply();
    mptr = N - 1;

    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_pulses", {20'd0, bus.req_ready, bus.req_done, 3'd0,
                         err_timeout}, 0);
      chk("rst_tx", {22'd0, bus.tx_en, bus.tx_data, active}, 0);
      chk("rst_owner", {30'd0, owner}, 0);
    end
    rst  = 1'b0;
    pend = '0;
    apply();
    step();

    pend = 4'hF;
    apply();
    run_round(1'b0);

    dat[0] = 8'h55;
    pend   = 4'b0001;
    apply();
    run_round(1'b0);

    force_busy = 1'b1;
    pend       = 4'b0100;
    apply();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("busy_hold", {28'd0, bus.req_ready}, 0);
    end
    force_busy = 1'b0;
    run_round(1'b0);

`ifdef UART_ARB_TIMEOUT_EN
    stuck = 1'b1;
    pend  = 4'b0011;
    apply();
    w = pick();
    grant_chk(w, 1);
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
    end
    chk("tmo_seen", {31'd0, err_timeout}, 1);
    chk("tmo_cycles", n, TMO);
    chk("tmo_tx_en", {31'd0, bus.tx_en}, 0);
    chk("tmo_active", {31'd0, active}, 0);
    chk("tmo_no_done", {28'd0, bus.req_done}, 0);
    mptr  = w;
    stuck = 1'b0;
    serve_one(1, 1'b0);
    pend = '0;
    apply();
    for (int c = 0; c < GAP + 2; c++) step();
`else
    stuck = 1'b1;
    pend  = 4'b1000;
    apply();
    w = pick();
    grant_chk(w, 1);
    for (int c = 0; c < TMO + 10; c++) begin
      step();
      chk("stuck_hold", {30'd0, bus.tx_en, err_timeout}, 2);
    end
    stuck = 1'b0;
    finish_chk(w);
    for (int c = 0; c < GAP + 2; c++) step();
`endif

    pend = 4'b0010;
    apply();
    w = pick();
    uart_div = 12;
    grant_chk(w, 1);
    for (int c = 0; c < 3; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_active", {31'd0, active}, 0);
    chk("midrst_tx_en", {31'd0, bus.tx_en}, 0);
    chk("midrst_owner", {30'd0, owner}, 0);
    mptr = N - 1;
    step();

    for (int r = 0; r < 40; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
      apply();
      run_round(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
